// File: rtl/clock_timer.sv
// rtl/clock_timer.sv - 12-hour BCD clock with prescaled second tick, set/start/reset commands and second/hour pulses
module clock_timer #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [3:0]  state,
    input  logic [23:0] setTimeBits,
    output logic [23:0] timeDigits,
    output logic        running,
    output logic        secondPulse,
    output logic        hourPulse
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST_COUNT = PW'(TICKS_PER_SEC - 1);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } runState_t;

    runState_t     runState;
    runState_t     runNext;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescNext;
    logic [23:0]   timeNext;
    logic [23:0]   advanced;

    logic cmdReset;
    logic cmdSet;
    logic cmdStart;
    logic tick;
    logic advance;
    logic digitsBad;
    logic minSecWrap;

    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic [3:0] nh1, nh0, nm1, nm0, ns1, ns0;

    assign {h1, h0, m1, m0, s1, s0} = timeDigits;

    assign cmdReset = (state == 4'd0);
    assign cmdSet   = (state == 4'd1);
    assign cmdStart = (state == 4'd3);

    assign running = (runState == RUNNING);
    assign tick    = running && (prescaler == LAST_COUNT);
    // Reset and set commands override a coinciding tick, so no advance and no pulses.
    assign advance = tick && !cmdReset && !cmdSet;

    assign minSecWrap = (s0 >= 4'd9) && (s1 >= 4'd5) && (m0 >= 4'd9) && (m1 >= 4'd5);
    assign digitsBad  = (s0 > 4'd9) || (s1 > 4'd9) || (m0 > 4'd9) || (m1 > 4'd9) ||
                        (h0 > 4'd9) || (h1 > 4'd1) || ((h1 == 4'd1) && (h0 > 4'd2));

    always_comb begin
        ns0 = s0 + 4'd1;
        ns1 = s1;
        nm0 = m0;
        nm1 = m1;
        nh0 = h0;
        nh1 = h1;
        if (s0 >= 4'd9) begin
            ns0 = 4'd0;
            ns1 = s1 + 4'd1;
            if (s1 >= 4'd5) begin
                ns1 = 4'd0;
                nm0 = m0 + 4'd1;
                if (m0 >= 4'd9) begin
                    nm0 = 4'd0;
                    nm1 = m1 + 4'd1;
                    if (m1 >= 4'd5) begin
                        nm1 = 4'd0;
                        // 12-hour sequence; 00 (after reset/load) steps to 01
                        if ((h1 == 4'd1) && (h0 == 4'd2)) begin
                            nh1 = 4'd0;
                            nh0 = 4'd1;
                        end else if (h0 == 4'd9) begin
                            nh1 = 4'd1;
                            nh0 = 4'd0;
                        end else begin
                            nh0 = h0 + 4'd1;
                        end
                    end
                end
            end
        end
        advanced = digitsBad ? 24'h010000 : {nh1, nh0, nm1, nm0, ns1, ns0};
    end

    always_comb begin
        runNext   = runState;
        prescNext = prescaler;
        timeNext  = timeDigits;
        if (cmdReset) begin
            runNext   = STOPPED;
            prescNext = '0;
            timeNext  = 24'h000000;
        end else if (cmdSet) begin
            runNext   = STOPPED;
            prescNext = '0;
            timeNext  = setTimeBits;
        end else if (cmdStart && !running) begin
            runNext   = RUNNING;
            prescNext = '0;
        end else if (running) begin
            if (tick) begin
                prescNext = '0;
                timeNext  = advanced;
            end else begin
                prescNext = prescaler + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            runState    <= STOPPED;
            prescaler   <= '0;
            timeDigits  <= 24'h000000;
            secondPulse <= 1'b0;
            hourPulse   <= 1'b0;
        end else begin
            runState    <= runNext;
            prescaler   <= prescNext;
            timeDigits  <= timeNext;
            secondPulse <= advance;
            hourPulse   <= advance && minSecWrap;
        end
    end

endmodule

// File: tb/tb_clock_timer.sv
// tb/tb_clock_timer.sv - directed self-checking bench for clock_timer with TICKS_PER_SEC=4
module tb_clock_timer;

    logic        clk;
    logic        resetN;
    logic [3:0]  state;
    logic [23:0] setTimeBits;
    logic [23:0] timeDigits;
    logic        running;
    logic        secondPulse;
    logic        hourPulse;

    int numChecks;
    int numFails;
    int pulseCount;

    clock_timer #(.TICKS_PER_SEC(4)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .state       (state),
        .setTimeBits (setTimeBits),
        .timeDigits  (timeDigits),
        .running     (running),
        .secondPulse (secondPulse),
        .hourPulse   (hourPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [23:0] got, input logic [23:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadTime(input logic [23:0] t);
        state       = 4'd1;
        setTimeBits = t;
        step();
    endtask

    task automatic startRun();
        state = 4'd3;
        step();
        state = 4'd4;
    endtask

    task automatic oneSecond(input logic [23:0] t, input logic [23:0] expTime, input logic expHour, input string tag);
        loadTime(t);
        startRun();
        repeat (4) step();
        checkVal({tag, "_time"}, timeDigits, expTime);
        checkVal({tag, "_sec"}, {23'd0, secondPulse}, 24'd1);
        checkVal({tag, "_hour"}, {23'd0, hourPulse}, {23'd0, expHour});
    endtask

    initial begin
        numChecks   = 0;
        numFails    = 0;
        resetN      = 1'b0;
        state       = 4'd4;
        setTimeBits = 24'h000000;
        step();
        step();
        checkVal("rst_time", timeDigits, 24'h000000);
        checkVal("rst_run", {23'd0, running}, 24'd0);
        checkVal("rst_sec", {23'd0, secondPulse}, 24'd0);
        checkVal("rst_hour", {23'd0, hourPulse}, 24'd0);
        resetN = 1'b1;
        step();
        checkVal("idle_after_rst", timeDigits, 24'h000000);

        // 12:59:58 -> 12:59:59 -> 01:00:00 with pulse spacing of 4 cycles
        loadTime(24'h125958);
        checkVal("set_time", timeDigits, 24'h125958);
        checkVal("set_run", {23'd0, running}, 24'd0);
        startRun();
        checkVal("start_run", {23'd0, running}, 24'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            checkVal("sec1_pulse", {23'd0, secondPulse}, {23'd0, (k == 4)});
        end
        checkVal("sec1_time", timeDigits, 24'h125959);
        checkVal("sec1_hour", {23'd0, hourPulse}, 24'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            checkVal("sec2_pulse", {23'd0, secondPulse}, {23'd0, (k == 4)});
        end
        checkVal("wrap12_time", timeDigits, 24'h010000);
        checkVal("wrap12_hour", {23'd0, hourPulse}, 24'd1);
        step();
        checkVal("pulse_clear_sec", {23'd0, secondPulse}, 24'd0);
        checkVal("pulse_clear_hour", {23'd0, hourPulse}, 24'd0);

        oneSecond(24'h005959, 24'h010000, 1'b1, "h00");
        oneSecond(24'h095959, 24'h100000, 1'b1, "h09");
        oneSecond(24'h115959, 24'h120000, 1'b1, "h11");
        oneSecond(24'h030509, 24'h030510, 1'b0, "s_carry");
        oneSecond(24'h031959, 24'h032000, 1'b0, "m_carry");
        oneSecond(24'h135959, 24'h010000, 1'b1, "bad_hour");
        oneSecond(24'h0A1234, 24'h010000, 1'b0, "bad_digit");

        // Set while running mid-second stops the clock
        loadTime(24'h032741);
        startRun();
        step();
        step();
        loadTime(24'h090500);
        checkVal("reset_set_time", timeDigits, 24'h090500);
        checkVal("reset_set_run", {23'd0, running}, 24'd0);
        state = 4'd4;
        pulseCount = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            pulseCount += int'(secondPulse);
        end
        checkVal("stopped_pulses", 24'(pulseCount), 24'd0);
        checkVal("stopped_time", timeDigits, 24'h090500);

        // state=2 keeps the clock advancing
        startRun();
        state = 4'd2;
        pulseCount = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            pulseCount += int'(secondPulse);
            checkVal("load_run", {23'd0, running}, 24'd1);
        end
        checkVal("load_pulses", 24'(pulseCount), 24'd2);
        checkVal("load_time", timeDigits, 24'h090502);

        // Prescaler is 2 here; one more cycle puts the tick on the reset edge
        state = 4'd4;
        step();
        state = 4'd0;
        step();
        checkVal("cmd_tick_time", timeDigits, 24'h000000);
        checkVal("cmd_tick_sec", {23'd0, secondPulse}, 24'd0);
        checkVal("cmd_tick_hour", {23'd0, hourPulse}, 24'd0);
        checkVal("cmd_tick_run", {23'd0, running}, 24'd0);

        // Asynchronous reset mid-second
        loadTime(24'h010203);
        startRun();
        step();
        step();
        resetN = 1'b0;
        #1;
        checkVal("async_time", timeDigits, 24'h000000);
        checkVal("async_run", {23'd0, running}, 24'd0);
        step();
        resetN = 1'b1;
        state  = 4'd4;
        pulseCount = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            pulseCount += int'(secondPulse);
        end
        checkVal("post_rst_time", timeDigits, 24'h000000);
        checkVal("post_rst_run", {23'd0, running}, 24'd0);
        checkVal("post_rst_pulses", 24'(pulseCount), 24'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
